jk_bank_seq: RTL and testbench
==============================

JK_BANK_SEQ -- requirements
Module: jk_bank_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of external JK flip-flop cells controlled (2..16).
REQ-002 SHALL have port CLK  input  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_n  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port CMD_VALID  input  1: command offered.
REQ-005 SHALL have port CMD_READY  output  1: command accepted when CMD_VALID and CMD_READY are both high on a CLK edge.
REQ-006 SHALL have port CMD_OP  input  3: opcode, sampled at acceptance.
REQ-007 SHALL have port CMD_ARG  input  WIDTH: bit mask, load pattern or step count, sampled at acceptance.
REQ-008 SHALL have port Q_IN  input  WIDTH: Q outputs of the external JK cell bank.
REQ-009 SHALL have port J_OUT  output  WIDTH: J inputs of the bank, combinational from state, latched argument and Q_IN.
REQ-010 SHALL have port K_OUT  output  WIDTH: K inputs of the bank, same timing as J_OUT.
REQ-011 SHALL have port BUSY  output  1: high in every state except IDLE.
REQ-012 SHALL have port DONE  output  1: one-cycle pulse on command completion.
REQ-013 SHALL have port ERR  output  1: one-cycle pulse when an illegal opcode is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, COUNT, DONE; CMD_READY high only in IDLE.
REQ-015 SHALL drive J_OUT = K_OUT = 0 (bank holds) in IDLE and DONE.
REQ-016 SHALL on acceptance latch CMD_OP/CMD_ARG and go to APPLY for ops 001-100, or to COUNT for 101/110 with ARG != 0.
REQ-017 SHALL in APPLY drive, for one cycle: 001 CLEAR J=0,K=ARG; 010 SET J=ARG,K=0; 011 TOGGLE J=K=ARG; 100 LOAD J=ARG,K=~ARG; then go to DONE.
REQ-018 SHALL treat op 000 (NOP) as: accepted, to DONE next cycle, J/K held at 0.
REQ-019 SHALL in COUNT drive up-count vector: J[0]=K[0]=1, J[i]=K[i]=AND of Q_IN[i-1:0]; one bank step per cycle.
REQ-020 SHALL load a WIDTH-bit step counter with ARG on COUNT entry, decrement it each COUNT cycle, and leave COUNT for DONE in the cycle the counter reads 1.
REQ-021 SHALL wrap the bank modulo 2^WIDTH (all-ones + 1 step -> zero) with no flag.
REQ-022 SHALL treat ops 101/110 with ARG == 0 as complete: to DONE, no step.
REQ-023 SHALL in DONE assert DONE for exactly one cycle, then return to IDLE; next command is accepted the cycle after DONE at the earliest.
REQ-024 SHALL on an illegal opcode (111, or 110 when down-count is not compiled in) pulse ERR and DONE together in the DONE state, with no J/K activity.
REQ-025 SHALL ignore CMD_VALID, CMD_OP and CMD_ARG changes while BUSY.

Reset
REQ-026 SHALL on RST_n low, immediately and regardless of CLK: state IDLE, CMD_READY 1, BUSY 0, DONE 0, ERR 0, J_OUT 0, K_OUT 0, step counter 0, latched op/arg 0.
REQ-027 SHALL abort any command in progress on reset, with no DONE pulse; bank contents are the bank's own reset responsibility.

Configuration
REQ-028 SHALL, when macro JK_BANK_SEQ_DOWN_EN is defined, support op 110 COUNT_DOWN: J[0]=K[0]=1, J[i]=K[i]=AND of ~Q_IN[i-1:0], counter/wrap rules as REQ-020..022 (zero - 1 -> all-ones).
REQ-029 SHALL, when JK_BANK_SEQ_DOWN_EN is undefined, contain no down-count logic and treat op 110 as illegal per REQ-024.

Verification
REQ-030 SHALL check reset mid-COUNT (WIDTH=4, COUNT_UP ARG=10, RST_n low after 3 steps) -> all outputs at reset values asynchronously, no DONE, bank at 0.
REQ-031 SHALL check LOAD ARG=4'b1010 from bank 0000 -> APPLY drives J=1010,K=0101 one cycle, bank 1010, DONE pulse 2 cycles after acceptance.
REQ-032 SHALL check COUNT_UP ARG=3 from bank 1110 -> bank 1111, 0000, 0001 on consecutive cycles, BUSY 4 cycles, one DONE.
REQ-033 SHALL check TOGGLE ARG=0110 then CLEAR ARG=1111 from 0011 -> 0101 then 0000.
REQ-034 SHALL check COUNT_UP ARG=0 -> DONE next cycle, bank unchanged; op 111 -> ERR and DONE same cycle, J/K stay 0.
REQ-035 SHALL check, with JK_BANK_SEQ_DOWN_EN, COUNT_DOWN ARG=2 from 0001 -> 0000, 1111; without it op 110 -> ERR.

Source files
------------

// File: rtl/jk_bank_seq.sv
// jk_bank_seq -- command sequencer for an external bank of JK flip-flop cells.
//
// A command (opcode + WIDTH-bit argument) is accepted in IDLE. The sequencer
// drives the J/K inputs of the bank: one cycle of CLEAR/SET/TOGGLE/LOAD, or a
// run of binary count steps. Then it pulses DONE for one cycle and returns to
// IDLE. An illegal opcode produces an ERR+DONE pulse and no J/K activity.
//
// Optional feature: define JK_BANK_SEQ_DOWN_EN to compile in op 110
// (COUNT_DOWN). Without the macro, op 110 is illegal and no down-count logic
// exists.
//
// Ports
//   CLK        rising-edge clock
//   RST_n      asynchronous active-low reset
//   CMD_VALID  command offered
//   CMD_READY  high in IDLE; the command is accepted on VALID & READY
//   CMD_OP     opcode, sampled at acceptance
//   CMD_ARG    mask / load pattern / step count, sampled at acceptance
//   Q_IN       Q outputs of the bank
//   J_OUT      J inputs of the bank (combinational)
//   K_OUT      K inputs of the bank (combinational)
//   BUSY       high in every state except IDLE
//   DONE       one-cycle completion pulse
//   ERR        one-cycle pulse, coincident with DONE, for an illegal opcode
module jk_bank_seq #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [2:0]       CMD_OP,
   input  logic [WIDTH-1:0] CMD_ARG,
   input  logic [WIDTH-1:0] Q_IN,
   output logic [WIDTH-1:0] J_OUT,
   output logic [WIDTH-1:0] K_OUT,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_APPLY = 2'b01,
      ST_COUNT = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_CLEAR  = 3'b001;
   localparam logic [2:0] OP_SET    = 3'b010;
   localparam logic [2:0] OP_TOGGLE = 3'b011;
   localparam logic [2:0] OP_LOAD   = 3'b100;
   localparam logic [2:0] OP_UP     = 3'b101;
   localparam logic [2:0] OP_DOWN   = 3'b110;
   localparam logic [2:0] OP_BAD    = 3'b111;

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt_s;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] arg_r;
   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] cnt_nxt_s;
   logic             accept_s;
   logic [WIDTH-1:0] up_vec_s;
   logic             unused_q_msb_s;

   // Opcodes that end in an ERR pulse.
   function automatic logic is_illegal(input logic [2:0] op);
`ifdef JK_BANK_SEQ_DOWN_EN
      is_illegal = (op == OP_BAD);
`else
      is_illegal = (op == OP_BAD) || (op == OP_DOWN);
`endif
   endfunction

   // Opcodes that run the step counter.
   function automatic logic is_count(input logic [2:0] op);
`ifdef JK_BANK_SEQ_DOWN_EN
      is_count = (op == OP_UP) || (op == OP_DOWN);
`else
      is_count = (op == OP_UP);
`endif
   endfunction

   // Ripple-carry toggle enables: cell i toggles when all lower cells are 1.
   assign up_vec_s[0] = 1'b1;
   for (genvar gi = 1; gi < WIDTH; gi++) begin : g_up
      assign up_vec_s[gi] = &Q_IN[gi-1:0];
   end

`ifdef JK_BANK_SEQ_DOWN_EN
   logic [WIDTH-1:0] dn_vec_s;
   // Borrow toggle enables: cell i toggles when all lower cells are 0.
   assign dn_vec_s[0] = 1'b1;
   for (genvar gd = 1; gd < WIDTH; gd++) begin : g_dn
      assign dn_vec_s[gd] = &(~Q_IN[gd-1:0]);
   end
`endif

   // The top cell never feeds a carry/borrow enable.
   assign unused_q_msb_s = Q_IN[WIDTH-1];

   assign accept_s  = CMD_VALID && (state_r == ST_IDLE);
   assign CMD_READY = (state_r == ST_IDLE);
   assign BUSY      = (state_r != ST_IDLE);
   assign DONE      = (state_r == ST_DONE);
   assign ERR       = (state_r == ST_DONE) && is_illegal(op_r);

   // State, step counter and latched command registers.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= ZERO_W;
         op_r    <= OP_NOP;
         arg_r   <= ZERO_W;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (accept_s) begin
            op_r  <= CMD_OP;
            arg_r <= CMD_ARG;
         end else begin
            op_r  <= op_r;
            arg_r <= arg_r;
         end
      end
   end

   // Next-state and step-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (CMD_VALID) begin
               if (is_illegal(CMD_OP)) begin
                  state_nxt_s = ST_DONE;
               end else if (is_count(CMD_OP)) begin
                  // A zero step count completes without touching the bank.
                  if (CMD_ARG == ZERO_W) begin
                     state_nxt_s = ST_DONE;
                  end else begin
                     state_nxt_s = ST_COUNT;
                     cnt_nxt_s   = CMD_ARG;
                  end
               end else if (CMD_OP == OP_NOP) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_APPLY;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_APPLY: begin
            state_nxt_s = ST_DONE;
         end
         ST_COUNT: begin
            // One bank step per cycle; the cycle that reads 1 is the last.
            cnt_nxt_s = cnt_r - ONE_W;
            if (cnt_r == ONE_W) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_COUNT;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = ZERO_W;
         end
      endcase
   end

   // J/K drive: the bank holds (J=K=0) except in APPLY and COUNT.
   always_comb begin
      J_OUT = ZERO_W;
      K_OUT = ZERO_W;
      case (state_r)
         ST_APPLY: begin
            case (op_r)
               OP_CLEAR:  begin J_OUT = ZERO_W; K_OUT = arg_r;  end
               OP_SET:    begin J_OUT = arg_r;  K_OUT = ZERO_W; end
               OP_TOGGLE: begin J_OUT = arg_r;  K_OUT = arg_r;  end
               OP_LOAD:   begin J_OUT = arg_r;  K_OUT = ~arg_r; end
               default:   begin J_OUT = ZERO_W; K_OUT = ZERO_W; end
            endcase
         end
         ST_COUNT: begin
`ifdef JK_BANK_SEQ_DOWN_EN
            if (op_r == OP_DOWN) begin
               J_OUT = dn_vec_s;
               K_OUT = dn_vec_s;
            end else begin
               J_OUT = up_vec_s;
               K_OUT = up_vec_s;
            end
`else
            J_OUT = up_vec_s;
            K_OUT = up_vec_s;
`endif
         end
         default: begin
            J_OUT = ZERO_W;
            K_OUT = ZERO_W;
         end
      endcase
   end

endmodule

// File: tb/tb_jk_bank_seq.sv
module tb_jk_bank_seq;

   localparam int W = 4;
`ifdef JK_BANK_SEQ_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic         CLK;
   logic         RST_n;
   logic         CMD_VALID;
   logic         CMD_READY;
   logic [2:0]   CMD_OP;
   logic [W-1:0] CMD_ARG;
   logic [W-1:0] J_OUT;
   logic [W-1:0] K_OUT;
   logic         BUSY;
   logic         DONE;
   logic         ERR;
   logic [W-1:0] bank_q;

   int n_checks = 0;
   int n_fail   = 0;

   jk_bank_seq #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .CMD_VALID (CMD_VALID),
      .CMD_READY (CMD_READY),
      .CMD_OP    (CMD_OP),
      .CMD_ARG   (CMD_ARG),
      .Q_IN      (bank_q),
      .J_OUT     (J_OUT),
      .K_OUT     (K_OUT),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // External JK cell bank, reset together with the sequencer.
   always @(posedge CLK or negedge RST_n) begin
      if (!RST_n) bank_q <= '0;
      else        bank_q <= (J_OUT & ~bank_q) | (~K_OUT & bank_q);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Command-level reference: resulting bank, cycles to DONE, error flag.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] nb, output int lat, output bit err);
      nb = b; lat = 1; err = 1'b0;
      case (op)
         3'd0: begin nb = b; lat = 1; end
         3'd1: begin nb = b & ~a; lat = 2; end
         3'd2: begin nb = b | a;  lat = 2; end
         3'd3: begin nb = b ^ a;  lat = 2; end
         3'd4: begin nb = a;      lat = 2; end
         3'd5: begin nb = b + a;  lat = (a == 0) ? 1 : int'(a) + 1; end
         3'd6: begin
            if (DOWN_EN) begin nb = b - a; lat = (a == 0) ? 1 : int'(a) + 1; end
            else begin nb = b; lat = 1; err = 1'b1; end
         end
         default: begin nb = b; lat = 1; err = 1'b1; end
      endcase
   endfunction

   // Issue one command from IDLE (called at a falling edge) and check it to completion.
   task automatic run_cmd(input string tag, input logic [2:0] op, input logic [W-1:0] arg,
                          input logic [W-1:0] start, input logic [W-1:0] exp_bank,
                          input int exp_lat, input bit exp_err, input bit junk);
      int done_at = 0;
      int busy_cnt = 0;
      int err_stray = 0;
      bit err_at = 1'b0;
      bit up_op;
      bit dn_op;
      logic [W-1:0] e;
      logic [W-1:0] ej;
      logic [W-1:0] ek;
      up_op = (op == 3'd5);
      dn_op = (op == 3'd6) && DOWN_EN;
      check({tag, " ready"}, 32'(CMD_READY), 32'd1);
      CMD_VALID = 1'b1; CMD_OP = op; CMD_ARG = arg;
      @(posedge CLK); #1;
      if (junk) begin
         CMD_VALID = 1'($urandom_range(0, 1)); CMD_OP = 3'($urandom_range(0, 7)); CMD_ARG = W'($urandom);
      end else begin
         CMD_VALID = 1'b0;
      end
      for (int n = 1; n <= 80; n++) begin
         @(negedge CLK);
         if (done_at != 0) begin
            check({tag, " after-done DONE"}, 32'(DONE), 32'd0);
            check({tag, " after-done READY"}, 32'(CMD_READY), 32'd1);
            break;
         end
         if (BUSY) busy_cnt++;
         if (ERR && !DONE) err_stray++;
         if (n == 1 && op >= 3'd1 && op <= 3'd4) begin
            ej = '0; ek = '0;
            case (op)
               3'd1:    begin ej = '0;  ek = arg;  end
               3'd2:    begin ej = arg; ek = '0;   end
               3'd3:    begin ej = arg; ek = arg;  end
               default: begin ej = arg; ek = ~arg; end
            endcase
            check({tag, " apply J"}, 32'(J_OUT), 32'(ej));
            check({tag, " apply K"}, 32'(K_OUT), 32'(ek));
         end
         if ((up_op || dn_op) && n <= int'(arg)) begin
            e = up_op ? start + W'(n - 1) : start - W'(n - 1);
            check({tag, " count bank"}, 32'(bank_q), 32'(e));
         end
         if (DONE) begin
            done_at = n;
            err_at = ERR;
            check({tag, " done J"}, 32'(J_OUT), 32'd0);
            check({tag, " done K"}, 32'(K_OUT), 32'd0);
            check({tag, " bank"}, 32'(bank_q), 32'(exp_bank));
            CMD_VALID = 1'b0;
         end else if (junk) begin
            CMD_VALID = 1'($urandom_range(0, 1)); CMD_OP = 3'($urandom_range(0, 7)); CMD_ARG = W'($urandom);
         end else begin
            CMD_VALID = 1'b0;
         end
      end
      CMD_VALID = 1'b0;
      check({tag, " latency"}, 32'(done_at), 32'(exp_lat));
      check({tag, " err"}, 32'(err_at), 32'(exp_err));
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
      check({tag, " stray err"}, 32'(err_stray), 32'd0);
   endtask

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] arg;
      logic [W-1:0] bank;
      int           lat;
      bit           err;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] model_bank;
      logic [W-1:0] nb;
      int lat;
      bit err;
      int dones;
      logic [2:0] rop;
      logic [W-1:0] rarg;

      tbl[0]  = '{3'd4, 4'b1010, 4'b1010, 2, 1'b0};   // LOAD from 0000
      tbl[1]  = '{3'd4, 4'b1110, 4'b1110, 2, 1'b0};
      tbl[2]  = '{3'd5, 4'd3,    4'b0001, 4, 1'b0};   // COUNT_UP 3 across wrap
      tbl[3]  = '{3'd4, 4'b0011, 4'b0011, 2, 1'b0};
      tbl[4]  = '{3'd3, 4'b0110, 4'b0101, 2, 1'b0};   // TOGGLE
      tbl[5]  = '{3'd1, 4'b1111, 4'b0000, 2, 1'b0};   // CLEAR
      tbl[6]  = '{3'd2, 4'b1001, 4'b1001, 2, 1'b0};   // SET
      tbl[7]  = '{3'd5, 4'd0,    4'b1001, 1, 1'b0};   // COUNT_UP 0
      tbl[8]  = '{3'd7, 4'b1111, 4'b1001, 1, 1'b1};   // illegal
      tbl[9]  = '{3'd0, 4'b0110, 4'b1001, 1, 1'b0};   // NOP
      tbl[10] = '{3'd4, 4'b0001, 4'b0001, 2, 1'b0};
`ifdef JK_BANK_SEQ_DOWN_EN
      tbl[11] = '{3'd6, 4'd2,    4'b1111, 3, 1'b0};   // COUNT_DOWN 2 across wrap
      tbl[12] = '{3'd5, 4'd15,   4'b1110, 16, 1'b0};
`else
      tbl[11] = '{3'd6, 4'd2,    4'b0001, 1, 1'b1};   // op 110 illegal
      tbl[12] = '{3'd5, 4'd15,   4'b0000, 16, 1'b0};
`endif

      RST_n = 1'b0; CMD_VALID = 1'b0; CMD_OP = 3'd0; CMD_ARG = '0;
      #3;
      check("reset READY", 32'(CMD_READY), 32'd1);
      check("reset BUSY", 32'(BUSY), 32'd0);
      check("reset DONE", 32'(DONE), 32'd0);
      check("reset ERR", 32'(ERR), 32'd0);
      check("reset J", 32'(J_OUT), 32'd0);
      check("reset K", 32'(K_OUT), 32'd0);
      @(negedge CLK);
      check("reset held BUSY", 32'(BUSY), 32'd0);
      RST_n = 1'b1;
      @(negedge CLK);

      model_bank = '0;
      for (int i = 0; i < 13; i++) begin
         run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].arg, model_bank, tbl[i].bank,
                 tbl[i].lat, tbl[i].err, 1'b0);
         model_bank = tbl[i].bank;
      end

      // Reset in the middle of a count: asynchronous, no DONE, bank cleared.
      run_cmd("preload", 3'd4, 4'b0000, model_bank, 4'b0000, 2, 1'b0, 1'b0);
      CMD_VALID = 1'b1; CMD_OP = 3'd5; CMD_ARG = 4'd10;
      @(posedge CLK); #1;
      CMD_VALID = 1'b0;
      repeat (4) @(negedge CLK);
      check("midcount bank", 32'(bank_q), 32'd3);
      check("midcount BUSY", 32'(BUSY), 32'd1);
      #2;
      RST_n = 1'b0;
      #1;
      check("async READY", 32'(CMD_READY), 32'd1);
      check("async BUSY", 32'(BUSY), 32'd0);
      check("async DONE", 32'(DONE), 32'd0);
      check("async ERR", 32'(ERR), 32'd0);
      check("async J", 32'(J_OUT), 32'd0);
      check("async K", 32'(K_OUT), 32'd0);
      check("async bank", 32'(bank_q), 32'd0);
      dones = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         if (DONE) dones++;
         if (c == 2) RST_n = 1'b1;
      end
      check("abort DONE pulses", 32'(dones), 32'd0);
      check("abort bank", 32'(bank_q), 32'd0);
      model_bank = '0;

      // Random commands, junk on the command port while busy.
      for (int r = 0; r < 40; r++) begin
         rop = 3'($urandom_range(0, 7));
         rarg = W'($urandom);
         model(rop, rarg, model_bank, nb, lat, err);
         run_cmd($sformatf("rnd%0d op%0d", r, rop), rop, rarg, model_bank, nb, lat, err, 1'b1);
         model_bank = nb;
         if ($urandom_range(0, 3) == 0) @(negedge CLK);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
